// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit UART CPU: opcodes, command and error
// encodings, and the program sequencer state type.
package cpu_pkg;

    localparam logic [3:0] OPC_OUT = 4'b0001;
    localparam logic [3:0] OPC_ADD = 4'b0010;
    localparam logic [3:0] OPC_SUB = 4'b0011;
    localparam logic [3:0] OPC_MUL = 4'b0100;
    localparam logic [3:0] OPC_NOP = 4'b0110;

    // Placed right after each canned program's output instruction.
    localparam logic [15:0] INSTR_DONE_MARKER = 16'h6F0F;

    localparam logic [1:0] CMD_ADD = 2'd0;
    localparam logic [1:0] CMD_SUB = 2'd1;
    localparam logic [1:0] CMD_MUL = 2'd2;
    localparam logic [1:0] CMD_BAD = 2'd3;
    localparam logic [1:0] CNT_BAD = 2'd3;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_ABORT   = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } seq_state_t;

endpackage

// File: rtl/prog_addr_map.sv
// Maps a job command (operation, operand count) to the start address of its
// canned program and flags commands that have no program.
module prog_addr_map
    import cpu_pkg::*;
#(
    parameter int PC_W      = 16,
    parameter int BASE_STEP = 100
) (
    input  logic [1:0]      cmd_op,
    input  logic [1:0]      cmd_cnt,
    output logic [PC_W-1:0] start_addr,
    output logic            legal
);

    logic [3:0] prog_idx;

    // Program index 3*op + cnt + 1, at most 13 even for illegal commands.
    assign prog_idx   = ({2'b00, cmd_op} << 1) + {2'b00, cmd_op} + {2'b00, cmd_cnt} + 4'd1;
    assign start_addr = PC_W'(BASE_STEP) * {{(PC_W-4){1'b0}}, prog_idx};
    assign legal      = (cmd_op != CMD_BAD) && (cmd_cnt != CNT_BAD);

endmodule

// File: rtl/prog_sequencer.sv
// Launch controller for instruction fetch: starts a canned program for each
// accepted job, walks the PC, drains the pipeline and reports done or error.
module prog_sequencer
    import cpu_pkg::*;
#(
    parameter int PC_W         = 16,
    parameter int BASE_STEP    = 100,
    parameter int DRAIN_CYCLES = 4,
    parameter int MAX_STEPS    = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [1:0]      cmd_op,
    input  logic [1:0]      cmd_cnt,
    input  logic            stall,
    input  logic            abort,
    input  logic [PC_W-1:0] instr_in,
    output logic [PC_W-1:0] pc_out,
    output logic            fetch_en,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [1:0]      err_code
);

    localparam int unsigned SW = $clog2(MAX_STEPS + 1);
    localparam int unsigned DW = $clog2(DRAIN_CYCLES + 1);

    seq_state_t      state, state_nxt;
    logic [PC_W-1:0] pc_nxt;
    logic [SW-1:0]   step_cnt, step_nxt;
    logic [DW-1:0]   drain_cnt, drain_nxt;
    logic            err_nxt;
    logic [1:0]      err_code_nxt;
    logic [PC_W-1:0] start_addr;
    logic            cmd_legal;
    logic            is_out_instr;
    logic            unused_operand_bits;

    prog_addr_map #(
        .PC_W      (PC_W),
        .BASE_STEP (BASE_STEP)
    ) u_addr_map (
        .cmd_op     (cmd_op),
        .cmd_cnt    (cmd_cnt),
        .start_addr (start_addr),
        .legal      (cmd_legal)
    );

    assign is_out_instr        = (instr_in[PC_W-1 -: 4] == OPC_OUT);
    // Only the opcode field matters to the sequencer.
    assign unused_operand_bits = ^instr_in[PC_W-5:0];

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state == ST_LAUNCH) || (state == ST_RUN) || (state == ST_DRAIN);
    assign fetch_en  = (state == ST_RUN) || (state == ST_DRAIN);
    assign done      = (state == ST_DONE);

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc_out;
        step_nxt     = step_cnt;
        drain_nxt    = drain_cnt;
        err_nxt      = 1'b0;
        err_code_nxt = err_code;

        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (!cmd_legal) begin
                        err_nxt      = 1'b1;
                        err_code_nxt = ERR_ILLEGAL;
                    end else begin
                        pc_nxt       = start_addr;
                        err_code_nxt = ERR_NONE;
                        state_nxt    = ST_LAUNCH;
                    end
                end
            end
            ST_LAUNCH: begin
                step_nxt  = '0;
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!stall) begin
                    pc_nxt = pc_out + 1'b1;
                    if (is_out_instr) begin
                        drain_nxt = DW'(DRAIN_CYCLES);
                        state_nxt = ST_DRAIN;
                    end else begin
                        step_nxt = step_cnt + 1'b1;
                        if (step_nxt == SW'(MAX_STEPS)) begin
                            err_nxt      = 1'b1;
                            err_code_nxt = ERR_TIMEOUT;
                            state_nxt    = ST_IDLE;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (!stall) begin
                    drain_nxt = drain_cnt - 1'b1;
                    if (drain_cnt <= DW'(1)) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Abort overrides whatever the active state decided; the PC keeps its value.
        if (abort && busy) begin
            state_nxt    = ST_IDLE;
            pc_nxt       = pc_out;
            err_nxt      = 1'b1;
            err_code_nxt = ERR_ABORT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            pc_out    <= '0;
            step_cnt  <= '0;
            drain_cnt <= '0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            state     <= state_nxt;
            pc_out    <= pc_nxt;
            step_cnt  <= step_nxt;
            drain_cnt <= drain_nxt;
            err       <= err_nxt;
            err_code  <= err_code_nxt;
        end
    end

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: directed job scenarios plus random
// jobs, each compared cycle by cycle against an expected trace built from the job rules.
module tb_prog_sequencer;
    import cpu_pkg::*;

    localparam int PC_W         = 16;
    localparam int BASE_STEP    = 100;
    localparam int DRAIN_CYCLES = 4;
    localparam int MAX_STEPS    = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_op;
    logic [1:0]      cmd_cnt;
    logic            stall;
    logic            abort;
    logic [PC_W-1:0] instr_in;
    logic [PC_W-1:0] pc_out;
    logic            fetch_en;
    logic            busy;
    logic            done;
    logic            err;
    logic [1:0]      err_code;

    logic [15:0] mem [0:1023];
    assign instr_in = mem[pc_out[9:0]];

    prog_sequencer #(
        .PC_W         (PC_W),
        .BASE_STEP    (BASE_STEP),
        .DRAIN_CYCLES (DRAIN_CYCLES),
        .MAX_STEPS    (MAX_STEPS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_cnt   (cmd_cnt),
        .stall     (stall),
        .abort     (abort),
        .instr_in  (instr_in),
        .pc_out    (pc_out),
        .fetch_en  (fetch_en),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] pc;
        logic        ready;
        logic        bsy;
        logic        fetch;
        logic        dn;
        logic        er;
        logic [1:0]  code;
    } rec_t;

    rec_t        q[$];
    bit          stall_pat [256];
    int          n_vec  = 0;
    int          n_miss = 0;
    logic [15:0] cur_pc;
    logic [1:0]  cur_code;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s at %0t: observed %0h, expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic rec_t mk(input logic [15:0] pc, input logic ready, input logic bsy,
                                input logic fetch, input logic dn, input logic er,
                                input logic [1:0] code);
        rec_t r;
        r.pc = pc; r.ready = ready; r.bsy = bsy; r.fetch = fetch;
        r.dn = dn; r.er = er; r.code = code;
        return r;
    endfunction

    function automatic bit st(input int c);
        return (c >= 0 && c < 256) ? stall_pat[c] : 1'b0;
    endfunction

    function automatic logic [15:0] rand_plain();
        logic [15:0] r;
        r = 16'($urandom);
        if (r[15:12] == OPC_OUT) r[15:12] = OPC_NOP;
        return r;
    endfunction

    // Program at start: ordinary instructions, output instruction at start+off (none if off>44).
    task automatic fill_prog(input int start, input int off);
        for (int i = 0; i < 45; i++) mem[(start + i) % 1024] = rand_plain();
        if (off < 45) mem[(start + off) % 1024] = {OPC_OUT, 12'($urandom)};
    endtask

    task automatic set_stalls(input int pct);
        for (int i = 0; i < 256; i++) stall_pat[i] = ($urandom_range(0, 99) < pct);
    endtask

    task automatic end_err(input logic [15:0] pc, input logic [1:0] code);
        q.push_back(mk(pc, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, code));
        q.push_back(mk(pc, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, code));
    endtask

    // Expected per-cycle trace from the LAUNCH cycle onward, from the job rules.
    task automatic gen(input logic [15:0] start, input int abort_at);
        int          c;
        int          n;
        int          left;
        logic [15:0] pc;
        q.delete();
        q.push_back(mk(start, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ERR_NONE));
        if (abort_at == 0) begin
            end_err(start, ERR_ABORT);
            return;
        end
        pc = start; n = 0; c = 1;
        forever begin
            q.push_back(mk(pc, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, ERR_NONE));
            if (abort_at == c) begin
                end_err(pc, ERR_ABORT);
                return;
            end
            c++;
            if (!st(c - 1)) begin
                if (mem[pc[9:0]][15:12] == OPC_OUT) begin
                    pc = pc + 16'd1;
                    break;
                end
                pc = pc + 16'd1;
                n++;
                if (n == MAX_STEPS) begin
                    end_err(pc, ERR_TIMEOUT);
                    return;
                end
            end
        end
        left = DRAIN_CYCLES;
        forever begin
            q.push_back(mk(pc, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, ERR_NONE));
            if (abort_at == c) begin
                end_err(pc, ERR_ABORT);
                return;
            end
            if (!st(c)) left--;
            c++;
            if (left == 0) break;
        end
        q.push_back(mk(pc, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ERR_NONE));
        q.push_back(mk(pc, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ERR_NONE));
    endtask

    task automatic play(input int abort_at, input int stop_after);
        rec_t r;
        for (int k = 0; k < q.size() && k < stop_after; k++) begin
            r     = q[k];
            stall = st(k);
            if (r.ready) begin
                cmd_valid = 1'b0;
                abort     = 1'($urandom_range(0, 1));
            end else begin
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_op    = 2'($urandom);
                cmd_cnt   = 2'($urandom);
                abort     = (k == abort_at);
            end
            #1;
            chk("pc_out", 32'(pc_out), 32'(r.pc));
            chk("flags{rdy,busy,fetch,done,err,code}",
                32'({cmd_ready, busy, fetch_en, done, err, err_code}),
                32'({r.ready, r.bsy, r.fetch, r.dn, r.er, r.code}));
            @(negedge clk);
        end
        cmd_valid = 1'b0; abort = 1'b0; stall = 1'b0;
        if (stop_after >= q.size()) begin
            cur_pc   = q[q.size() - 1].pc;
            cur_code = q[q.size() - 1].code;
        end
    endtask

    // Entered just after a falling edge with the sequencer idle.
    task automatic job(input logic [1:0] op, input logic [1:0] cnt, input int abort_at,
                       input int stop_after);
        logic [15:0] start;
        cmd_valid = 1'b1; cmd_op = op; cmd_cnt = cnt;
        stall = 1'($urandom); abort = 1'($urandom);
        #1;
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0; abort = 1'b0; stall = 1'b0;
        if (op == 2'd3 || cnt == 2'd3) begin
            #1;
            chk("illegal_flags", 32'({cmd_ready, busy, fetch_en, done, err, err_code}),
                32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b1, ERR_ILLEGAL}));
            chk("illegal_pc", 32'(pc_out), 32'(cur_pc));
            @(negedge clk);
            #1;
            chk("illegal_after", 32'({cmd_ready, busy, fetch_en, done, err, err_code}),
                32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ERR_ILLEGAL}));
            @(negedge clk);
            cur_code = ERR_ILLEGAL;
            return;
        end
        start = 16'(BASE_STEP * (3 * int'(op) + int'(cnt) + 1));
        gen(start, abort_at);
        play(abort_at, stop_after);
    endtask

    initial begin
        int op, cnt, off, ab;
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_cnt = '0;
        stall = 1'b0; abort = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = INSTR_DONE_MARKER;
        cur_pc = '0; cur_code = ERR_NONE;
        #1;
        chk("reset_pc", 32'(pc_out), 32'd0);
        chk("reset_flags", 32'({cmd_ready, busy, fetch_en, done, err, err_code}),
            32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0}));
        @(negedge clk);
        reset = 1'b0;

        // ADD/2, output instruction at 107, no stalls.
        fill_prog(100, 99); mem[107] = 16'h1F0F; set_stalls(0);
        job(CMD_ADD, 2'd0, -1, 1000);

        // MUL/4 with a three-cycle stall while the PC sits at 905.
        fill_prog(900, 10); set_stalls(0);
        stall_pat[6] = 1'b1; stall_pat[7] = 1'b1; stall_pat[8] = 1'b1;
        job(CMD_MUL, 2'd2, -1, 1000);

        job(CMD_BAD, 2'd0, -1, 1000);
        job(CMD_SUB, CNT_BAD, -1, 1000);

        // SUB/3 runs off the end of its program.
        fill_prog(500, 99); set_stalls(0);
        job(CMD_SUB, 2'd1, -1, 1000);

        // SUB/3 aborted in its second RUN cycle, then ADD/3 from 200.
        fill_prog(500, 6); set_stalls(0);
        job(CMD_SUB, 2'd1, 2, 1000);
        fill_prog(200, 5); set_stalls(20);
        job(CMD_ADD, 2'd1, -1, 1000);

        // Reset in the middle of DRAIN, then a command right after release.
        fill_prog(100, 7); set_stalls(0);
        job(CMD_ADD, 2'd0, -1, 11);
        #2 reset = 1'b1;
        #1;
        chk("midjob_reset_pc", 32'(pc_out), 32'd0);
        chk("midjob_reset_flags", 32'({cmd_ready, busy, fetch_en, done, err, err_code}),
            32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0}));
        @(negedge clk);
        reset = 1'b0; cur_pc = '0; cur_code = ERR_NONE;
        job(CMD_ADD, 2'd0, -1, 1000);

        for (int j = 0; j < 40; j++) begin
            op  = $urandom_range(0, 3);
            cnt = $urandom_range(0, 3);
            off = $urandom_range(0, 40);
            ab  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 30)) : -1;
            if (op != 3 && cnt != 3) fill_prog(BASE_STEP * (3 * op + cnt + 1), off);
            set_stalls(25);
            job(2'(op), 2'(cnt), ab, 1000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
